// File: rtl/alu_seq_if.sv
// E-stage to multiply/divide unit bundle.
// The master is the pipeline; the slave is alu_seq.
interface alu_seq_if;
  logic        E_valid;
  logic [5:0]  E_op;
  logic [5:0]  E_func;
  logic [31:0] E_valA;
  logic [31:0] E_valB;
  logic        e_stall;
  logic [31:0] e_mdval;

  modport master (
    output E_valid, E_op, E_func, E_valA, E_valB,
    input  e_stall, e_mdval
  );

  modport slave (
    input  E_valid, E_op, E_func, E_valA, E_valB,
    output e_stall, e_mdval
  );
endinterface

// File: rtl/alu_seq.sv
// Iterative unsigned multiply/divide unit with HI/LO registers.
// Shift-add multiply, restoring divide, one bit per cycle.
module alu_seq #(
  parameter int MUL_CYC = 32,
  parameter int DIV_CYC = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    e,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] IROP    = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam int MAXC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [63:0] acc;

  logic        isR;
  logic        isMultu;
  logic        isDivu;
  logic        isMfhi;
  logic        isMflo;
  logic        accMul;
  logic        accDiv;
  logic [32:0] mulSum;
  logic [32:0] divSh;
  logic [32:0] divDiff;
  logic        divBit;
  logic [31:0] divRem;

  assign isR     = e.E_op == IROP;
  assign isMultu = isR && (e.E_func == F_MULTU);
  assign isDivu  = isR && (e.E_func == F_DIVU);
  assign isMfhi  = isR && (e.E_func == F_MFHI);
  assign isMflo  = isR && (e.E_func == F_MFLO);

  assign accMul = (state == IDLE) && e.E_valid && isMultu;
  assign accDiv = (state == IDLE) && e.E_valid && isDivu;

  // busy is forced low while reset is held, even before the reset edge
  assign busy = rst_n && (state != IDLE);

  assign e.e_stall = busy && e.E_valid &&
    (isMultu || isDivu || isMfhi || isMflo);

  always_comb begin
    e.e_mdval = '0;
    unique case (1'b1)
      isMfhi:  e.e_mdval = hi;
      isMflo:  e.e_mdval = lo;
      default: e.e_mdval = '0;
    endcase
  end

  // acc holds {product_hi, product_lo} or {remainder, quotient}
  assign mulSum  = {1'b0, acc[63:32]}
                 + (opB[0] ? {1'b0, opA} : 33'd0);
  assign divSh   = {acc[63:32], acc[31]};
  assign divDiff = divSh - {1'b0, opA};
  assign divBit  = divSh >= {1'b0, opA};
  assign divRem  = divBit ? divDiff[31:0] : divSh[31:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      opA   <= '0;
      opB   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accMul) begin
            opA   <= e.E_valA;
            opB   <= e.E_valB;
            acc   <= '0;
            cnt   <= CW'(MUL_CYC - 1);
            state <= MUL;
          end else if (accDiv) begin
            if (e.E_valB == '0) begin
              acc   <= {e.E_valA, 32'hFFFF_FFFF};
              cnt   <= '0;
              state <= DONE;
            end else begin
              opA   <= e.E_valB;
              acc   <= {32'd0, e.E_valA};
              cnt   <= CW'(DIV_CYC - 1);
              state <= DIV;
            end
          end
        end
        MUL: begin
          acc <= {mulSum, acc[31:1]};
          opB <= opB >> 1;
          cnt <= (cnt == '0) ? '0 : cnt - 1'b1;
          if (cnt == '0) state <= DONE;
        end
        DIV: begin
          acc <= {divRem, acc[30:0], divBit};
          cnt <= (cnt == '0) ? '0 : cnt - 1'b1;
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          hi    <= acc[63:32];
          lo    <= acc[31:0];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: multiply, divide, stalls,
// back-to-back issue and reset abort.
module tb_alu_seq;

  localparam logic [5:0] IROP    = 6'h00;
  localparam logic [5:0] IADDI   = 6'h08;
  localparam logic [5:0] ISW     = 6'h2B;
  localparam logic [5:0] IJ      = 6'h02;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  alu_seq_if eIf ();

  alu_seq #(
    .MUL_CYC(32),
    .DIV_CYC(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .e    (eIf),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb[$];

  function automatic logic [63:0] model(
    input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f == F_MULTU) return 64'(a) * 64'(b);
    if (b == 0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic drive(input logic v, input logic [5:0] op,
                       input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    eIf.E_valid = v;
    eIf.E_op    = op;
    eIf.E_func  = f;
    eIf.E_valA  = a;
    eIf.E_valB  = b;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    drive(1'b1, IROP, f, a, b);
    sb.push_back(model(f, a, b));
    @(posedge clk);
    #1;
    drive(1'b0, IROP, F_MULTU, $urandom, $urandom);
  endtask

  task automatic waitDone(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      eIf.E_valA = $urandom;
      eIf.E_valB = $urandom;
      if (!busy) break;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, IROP, F_MULTU, 32'd5, 32'd6);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (eIf.e_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b want 0", eIf.e_stall);
    end
    checks++;
    if ({hi, lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo got %h want 0", {hi, lo});
    end
    drive(1'b0, IROP, 6'h0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul;
    int n;
    logic [63:0] exp;
    logic [31:0] a;
    logic [31:0] b;
    @(negedge clk);
    issue(F_MULTU, 32'hFFFF_FFFF, 32'd2);
    waitDone(n);
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL mul_busy_cycles got %0d want 33", n);
    end
    exp = sb.pop_front();
    checks++;
    if ({hi, lo} !== exp) begin
      errors++;
      $display("FAIL mul_result got %h want %h", {hi, lo}, exp);
    end
    drive(1'b1, IROP, F_MFHI, 32'd0, 32'd0);
    #1;
    checks++;
    if (eIf.e_mdval !== 32'd1 || eIf.e_stall !== 1'b0) begin
      errors++;
      $display("FAIL mfhi got %h/%b want 1/0", eIf.e_mdval, eIf.e_stall);
    end
    eIf.E_func = F_MFLO;
    #1;
    checks++;
    if (eIf.e_mdval !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mflo got %h want fffffffe", eIf.e_mdval);
    end
    drive(1'b0, IROP, 6'h0, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      issue(F_MULTU, a, b);
      waitDone(n);
      exp = sb.pop_front();
      checks++;
      if ({hi, lo} !== exp || n != 33) begin
        errors++;
        $display("FAIL mul_rand %h*%h got %h/%0d want %h/33",
                 a, b, {hi, lo}, n, exp);
      end
    end
  endtask

  task automatic test_div;
    int n;
    logic [63:0] exp;
    logic [31:0] a;
    logic [31:0] b;
    @(negedge clk);
    issue(F_DIVU, 32'd100, 32'd7);
    waitDone(n);
    exp = sb.pop_front();
    checks++;
    if (n != 33 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL div_100_7 got %0d/%h want 33/%h", n, {hi, lo}, exp);
    end
    issue(F_DIVU, 32'd35, 32'd17);
    waitDone(n);
    exp = sb.pop_front();
    checks++;
    if ({hi, lo} !== exp || n != 33) begin
      errors++;
      $display("FAIL div_35_17 got %h/%0d want %h/33", {hi, lo}, n, exp);
    end
    issue(F_DIVU, 32'd35, 32'd0);
    waitDone(n);
    exp = sb.pop_front();
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL div0_busy got %0d want 1", n);
    end
    checks++;
    if ({hi, lo} !== exp) begin
      errors++;
      $display("FAIL div0_result got %h want %h", {hi, lo}, exp);
    end
    for (int k = 0; k < 4; k++) begin
      a = $urandom;
      b = (k == 2) ? 32'd0 : $urandom >> (k * 8);
      @(negedge clk);
      issue(F_DIVU, a, b);
      waitDone(n);
      exp = sb.pop_front();
      checks++;
      if ({hi, lo} !== exp || n != ((b == 0) ? 1 : 33)) begin
        errors++;
        $display("FAIL div_rand %h/%h got %h/%0d want %h",
                 a, b, {hi, lo}, n, exp);
      end
    end
  endtask

  task automatic test_ordinary;
    int n;
    logic [63:0] exp;
    logic [5:0] ops[3];
    ops[0] = IADDI;
    ops[1] = ISW;
    ops[2] = IJ;
    @(negedge clk);
    issue(F_MULTU, 32'd35, 32'd17);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, ops[k], F_MULTU, $urandom, $urandom);
      #1;
      checks++;
      if (eIf.e_stall !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL ord_stall op %h got stall %b busy %b want 0/1",
                 ops[k], eIf.e_stall, busy);
      end
    end
    @(negedge clk);
    drive(1'b1, IROP, F_MFLO, 32'd0, 32'd0);
    #1;
    n = 0;
    while (eIf.e_stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (n != 30) begin
      errors++;
      $display("FAIL mflo_stall_cycles got %0d want 30", n);
    end
    checks++;
    if (eIf.e_mdval !== 32'd595) begin
      errors++;
      $display("FAIL mflo_value got %0d want 595", eIf.e_mdval);
    end
    exp = sb.pop_front();
    checks++;
    if ({hi, lo} !== exp) begin
      errors++;
      $display("FAIL ord_result got %h want %h", {hi, lo}, exp);
    end
    drive(1'b0, IROP, 6'h0, 32'd0, 32'd0);
  endtask

  task automatic test_back_to_back;
    int n;
    logic [63:0] exp;
    @(negedge clk);
    issue(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    drive(1'b1, IROP, F_DIVU, 32'd100, 32'd7);
    #1;
    n = 0;
    while (eIf.e_stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL b2b_stall_cycles got %0d want 33", n);
    end
    exp = sb.pop_front();
    checks++;
    if ({hi, lo} !== exp) begin
      errors++;
      $display("FAIL b2b_mul got %h want %h", {hi, lo}, exp);
    end
    sb.push_back(model(F_DIVU, 32'd100, 32'd7));
    @(posedge clk);
    #1;
    drive(1'b0, IROP, 6'h0, 32'd0, 32'd0);
    waitDone(n);
    exp = sb.pop_front();
    checks++;
    if ({hi, lo} !== exp || n != 33) begin
      errors++;
      $display("FAIL b2b_div got %h/%0d want %h/33", {hi, lo}, n, exp);
    end
  endtask

  task automatic test_reset_abort;
    int n;
    logic [63:0] exp;
    @(negedge clk);
    issue(F_MULTU, 32'd35, 32'd17);
    void'(sb.pop_back());
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, IROP, F_MFHI, 32'd0, 32'd0);
    #1;
    checks++;
    if (busy !== 1'b0 || eIf.e_stall !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got %b/%b want 0/0", busy, eIf.e_stall);
    end
    checks++;
    if ({hi, lo} !== 64'd0 || eIf.e_mdval !== 32'd0) begin
      errors++;
      $display("FAIL abort_hilo got %h/%h want 0", {hi, lo}, eIf.e_mdval);
    end
    drive(1'b0, IROP, 6'h0, 32'd0, 32'd0);
    @(negedge clk);
    issue(F_MULTU, 32'd35, 32'd17);
    waitDone(n);
    exp = sb.pop_front();
    checks++;
    if ({hi, lo} !== exp || n != 33) begin
      errors++;
      $display("FAIL post_reset_mul got %h/%0d want %h/33",
               {hi, lo}, n, exp);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, IROP, 6'h0, 32'd0, 32'd0);
    test_reset();
    test_mul();
    test_div();
    test_ordinary();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameters SHALL be: MUL_CYC, default 32, number of multiply iterations; DIV_CYC, default 32, number of divide iterations.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 E_valid  input  1  E-stage holds a valid instruction this cycle.
REQ-005 E_op  input  6  E-stage opcode (`IROP, `IADDI, `IANDI, `IORI, `ISW, `ILW, `IJ encoding).
REQ-006 E_func  input  6  E-stage function field, meaningful only when E_op==`IROP.
REQ-007 E_valA  input  32  operand A (rs).
REQ-008 E_valB  input  32  operand B (rt).
REQ-009 e_stall  output  1  freeze F/D/E and insert bubble into M.
REQ-010 busy  output  1  iterative operation in progress.
REQ-011 hi  output  32  HI register.
REQ-012 lo  output  32  LO register.
REQ-013 e_mdval  output  32  value for MFHI/MFLO in E (hi or lo per E_func; 0 otherwise).

Function
REQ-014 Recognised R-type funcs SHALL be: MULTU 6'h19, DIVU 6'h1B, MFHI 6'h10, MFLO 6'h12; all other ops are "ordinary".
REQ-015 FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-016 IDLE + E_valid + MULTU SHALL latch A as multiplicand, B as multiplier, clear accumulator, load counter=MUL_CYC-1, go MUL.
REQ-017 IDLE + E_valid + DIVU with E_valB!=0 SHALL latch dividend A, divisor B, clear remainder, load counter=DIV_CYC-1, go DIV.
REQ-018 DIVU with E_valB==0 SHALL go directly to DONE with result HI=E_valA, LO=32'hFFFFFFFF.
REQ-019 MUL SHALL perform one shift-add step per cycle (1 multiplier bit, 64-bit unsigned product); DIV SHALL perform one restoring shift-subtract step per cycle (unsigned quotient/remainder).
REQ-020 Counter SHALL decrement each MUL/DIV cycle; at counter==0 the step completes and state goes DONE.
REQ-021 DONE SHALL write HI (product[63:32] / remainder) and LO (product[31:0] / quotient) on its edge and return to IDLE.
REQ-022 Latency: MULTU/DIVU accepted at edge N -> hi/lo visible after edge N+MUL_CYC+1 (33 cycles for defaults); divide-by-zero visible after edge N+1.
REQ-023 busy SHALL be 1 in MUL, DIV, DONE; 0 in IDLE.
REQ-024 The accepting MULTU/DIVU SHALL NOT stall; it leaves E the next cycle.
REQ-025 e_stall SHALL be combinational: 1 when busy AND E_valid AND E-stage op is MULTU, DIVU, MFHI or MFLO; ordinary instructions SHALL proceed while busy.
REQ-026 A stalled MULTU/DIVU SHALL be accepted in the cycle after DONE (IDLE); a stalled MFHI/MFLO SHALL read the updated hi/lo in that cycle.
REQ-027 e_mdval SHALL be combinational from the hi/lo registers, never from in-flight partial results.
REQ-028 E_valid==0 SHALL never start an operation or assert e_stall.
REQ-029 Operand inputs SHALL be ignored outside the accepting cycle.

Reset
REQ-030 rst_n==0 at an edge SHALL force IDLE, counter=0, hi=0, lo=0, all partial registers=0, regardless of state.
REQ-031 During reset cycles e_stall and busy SHALL be 0; an operation aborted by reset SHALL leave hi/lo at 0.
REQ-032 First E_valid MULTU/DIVU after rst_n rises SHALL be accepted normally.

Verification
REQ-033 MULTU A=32'hFFFFFFFF, B=2 -> busy for 33 cycles; then hi=1, lo=32'hFFFFFFFE.
REQ-034 DIVU A=100, B=7 -> after 33 cycles lo=14, hi=2; DIVU A=35, B=17 -> lo=2, hi=1.
REQ-035 DIVU A=35, B=0 -> busy 1 cycle; hi=35, lo=32'hFFFFFFFF.
REQ-036 MULTU 35x17 then `IADDI, `ISW, `IJ, then MFLO -> ordinary ops see e_stall=0; MFLO stalls until DONE, then e_mdval=595.
REQ-037 MULTU issued back-to-back with DIVU -> DIVU stalls for exactly 33 cycles, accepted in IDLE cycle, both results correct in sequence.
REQ-038 rst_n low for 1 cycle at iteration 10 of MULTU -> next cycle IDLE, busy=0, hi=lo=0, e_stall=0.
